// File: rtl/tdc_uart_framer.sv
// Buffers 32-bit TDC words in a FIFO and sends each one as a 6-byte frame
// (sync, data MSB first, XOR checksum) to a byte UART using its active/done handshake.
module tdc_uart_framer #(
  parameter int          DEPTH     = 16,
  parameter logic [7:0]  SYNC_BYTE = 8'hAA
) (
  input  logic                     i_Clock,
  input  logic                     i_Rst_L,
  input  logic                     i_Data_Valid,
  input  logic [31:0]              i_Data,
  output logic                     o_Data_Ready,
  output logic                     o_Tx_DV,
  output logic [7:0]               o_Tx_Byte,
  input  logic                     i_Tx_Active,
  input  logic                     i_Tx_Done,
  output logic                     o_Busy,
  output logic [$clog2(DEPTH):0]   o_Fifo_Count,
  output logic                     o_Overflow
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SEND,
    S_WAIT_ACT,
    S_WAIT_DONE,
    S_GAP
  } state_t;

  state_t      state_q;
  logic [31:0] mem_q [DEPTH];
  logic [AW:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0] count;
  logic        full, push, pop;
  logic        overflow_q;
  logic [31:0] hold_q;
  logic [2:0]  idx_q;
  logic        tx_dv_q;
  logic [7:0]  tx_byte_q;
  logic        busy_q;

  // Pointers carry one extra wrap bit, so their difference is the occupancy.
  assign count        = wr_ptr_q - rd_ptr_q;
  assign full         = (count == (AW+1)'(DEPTH));
  assign push         = i_Data_Valid && !full;
  assign pop          = (state_q == S_IDLE) && (count != '0);

  assign o_Data_Ready = !full;
  assign o_Fifo_Count = count;
  assign o_Overflow   = overflow_q;
  assign o_Tx_DV      = tx_dv_q;
  assign o_Tx_Byte    = tx_byte_q;
  assign o_Busy       = busy_q;

  function automatic logic [7:0] frame_byte(input logic [2:0] idx, input logic [31:0] w);
    case (idx)
      3'd0:    frame_byte = SYNC_BYTE;
      3'd1:    frame_byte = w[31:24];
      3'd2:    frame_byte = w[23:16];
      3'd3:    frame_byte = w[15:8];
      3'd4:    frame_byte = w[7:0];
      default: frame_byte = w[31:24] ^ w[23:16] ^ w[15:8] ^ w[7:0];
    endcase
  endfunction

  always_ff @(posedge i_Clock) begin
    if (push) mem_q[wr_ptr_q[AW-1:0]] <= i_Data;
  end

  always_ff @(posedge i_Clock or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      if (i_Data_Valid && full) overflow_q <= 1'b1;
    end
  end

  // Strobe and byte are registered on entry to SEND, so o_Tx_DV is high exactly while in SEND.
  always_ff @(posedge i_Clock or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      state_q   <= S_IDLE;
      hold_q    <= '0;
      idx_q     <= '0;
      tx_dv_q   <= 1'b0;
      tx_byte_q <= 8'h00;
      busy_q    <= 1'b0;
    end else begin
      tx_dv_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (pop) begin
            hold_q    <= mem_q[rd_ptr_q[AW-1:0]];
            idx_q     <= 3'd0;
            tx_dv_q   <= 1'b1;
            tx_byte_q <= SYNC_BYTE;
            busy_q    <= 1'b1;
            state_q   <= S_SEND;
          end
        end
        S_SEND:      state_q <= S_WAIT_ACT;
        S_WAIT_ACT:  if (i_Tx_Active) state_q <= S_WAIT_DONE;
        S_WAIT_DONE: if (i_Tx_Done)   state_q <= S_GAP;
        S_GAP: begin
          if (!i_Tx_Done) begin
            if (idx_q == 3'd5) begin
              busy_q  <= 1'b0;
              state_q <= S_IDLE;
            end else begin
              idx_q     <= idx_q + 3'd1;
              tx_dv_q   <= 1'b1;
              tx_byte_q <= frame_byte(idx_q + 3'd1, hold_q);
              state_q   <= S_SEND;
            end
          end
        end
        default:     state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tdc_uart_framer.sv
// Scoreboard bench for tdc_uart_framer: a reference model queues expected frame bytes
// per accepted word, and a monitor pops and compares them on every byte strobe.
module tb_tdc_uart_framer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        valid;
  logic [31:0] data;
  logic        ready;
  logic        tx_dv;
  logic [7:0]  tx_byte;
  logic        tx_active;
  logic        tx_done;
  logic        busy;
  logic [4:0]  fifo_count;
  logic        overflow;

  int tests = 0;
  int fails = 0;
  int dv_cnt = 0;
  int reset_gen = 0;
  logic tx_stuck = 1'b0;
  logic prev_dv = 1'b0;
  logic [7:0] exp_q[$];

  always #5 clk = ~clk;

  tdc_uart_framer #(.DEPTH(16), .SYNC_BYTE(8'hAA)) dut (
    .i_Clock(clk), .i_Rst_L(rst_n), .i_Data_Valid(valid), .i_Data(data),
    .o_Data_Ready(ready), .o_Tx_DV(tx_dv), .o_Tx_Byte(tx_byte),
    .i_Tx_Active(tx_active), .i_Tx_Done(tx_done), .o_Busy(busy),
    .o_Fifo_Count(fifo_count), .o_Overflow(overflow)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference frame: sync, four data bytes MSB first, XOR of the data bytes.
  task automatic add_word(input logic [31:0] w);
    logic [7:0] b [4];
    for (int i = 0; i < 4; i++) b[i] = w[31-8*i -: 8];
    exp_q.push_back(8'hAA);
    for (int i = 0; i < 4; i++) exp_q.push_back(b[i]);
    exp_q.push_back(b[0] ^ b[1] ^ b[2] ^ b[3]);
  endtask

  // Transmitter model: 10 bits x 4 clocks of activity, then done high for 2 cycles.
  initial begin
    logic [7:0] cap;
    int gen;
    tx_active = 1'b0;
    tx_done   = 1'b0;
    forever begin
      @(negedge clk);
      if (tx_dv && !tx_stuck) begin
        cap = tx_byte;
        gen = reset_gen;
        @(posedge clk); #1 tx_active = 1'b1;
        repeat (40) @(posedge clk);
        #1 tx_active = 1'b0; tx_done = 1'b1;
        if (gen == reset_gen && rst_n) chk("byte_stable", tx_byte, cap);
        repeat (2) @(posedge clk);
        #1 tx_done = 1'b0;
      end
    end
  end

  // Monitor: every strobe must match the head of the scoreboard and respect the handshake.
  always @(negedge clk) begin
    if (rst_n && tx_dv) begin
      dv_cnt++;
      chk("dv_spacing", {29'd0, prev_dv, tx_active, tx_done}, 32'd0);
      if (exp_q.size() == 0) begin
        tests++; fails++;
        $display("FAIL unexpected_dv: got byte %0h expected no strobe at %0t", tx_byte, $time);
      end else begin
        chk("tx_byte", tx_byte, exp_q.pop_front());
      end
    end
    prev_dv = rst_n && tx_dv;
  end

  task automatic push_word(input logic [31:0] w, input logic exp_acc);
    @(negedge clk);
    valid = 1'b1;
    data  = w;
    chk("data_ready", ready, exp_acc);
    if (exp_acc) add_word(w);
    @(posedge clk); #1;
    valid = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(!busy && fifo_count == 0 && !tx_active && !tx_done) && n < budget);
    if (n >= budget) begin
      tests++; fails++;
      $display("FAIL wait_idle: got timeout after %0d cycles expected idle", n);
    end
    chk("scoreboard_empty", exp_q.size(), 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    reset_gen++;
    exp_q.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    logic [31:0] w3 [3];
    int          cnt3 [4];
    int          seen;
    int          n;
    int          snap;
    rst_n = 1'b0;
    valid = 1'b0;
    data  = '0;
    repeat (3) @(negedge clk);
    chk("rst_dv", tx_dv, 0);
    chk("rst_byte", tx_byte, 8'h00);
    chk("rst_busy", busy, 0);
    chk("rst_count", fifo_count, 0);
    chk("rst_ready", ready, 1);
    chk("rst_ovf", overflow, 0);
    rst_n = 1'b1;

    // Single word: latency of the first strobe, then the full frame.
    dv_cnt = 0;
    push_word(32'h12345678, 1'b1);
    @(negedge clk);
    chk("n1_count", fifo_count, 1);
    chk("n1_dv", tx_dv, 0);
    chk("n1_busy", busy, 0);
    @(negedge clk);
    chk("n2_count", fifo_count, 0);
    chk("n2_dv", tx_dv, 1);
    chk("n2_byte", tx_byte, 8'hAA);
    chk("n2_busy", busy, 1);
    @(negedge clk);
    chk("n3_dv", tx_dv, 0);
    wait_idle(2000);
    chk("single_dv_cnt", dv_cnt, 6);

    // Three consecutive words; push and pop share the second edge.
    w3[0] = 32'h00000000; w3[1] = 32'hFFFFFFFF; w3[2] = 32'hA5A5A5A5;
    cnt3[1] = 1; cnt3[2] = 1; cnt3[3] = 2;
    dv_cnt = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (k > 0) chk("pp_count", fifo_count, cnt3[k]);
      if (k < 3) begin
        valid = 1'b1;
        data  = w3[k];
        add_word(w3[k]);
      end else begin
        valid = 1'b0;
      end
    end
    wait_idle(6000);
    chk("three_dv_cnt", dv_cnt, 18);

    // Stalled transmitter: FIFO fills, 18th push is rejected and flagged.
    do_reset();
    tx_stuck = 1'b1;
    dv_cnt = 0;
    for (int i = 0; i < 18; i++) begin
      push_word($urandom, i < 17);
      if (i == 16) chk("ovf_before", overflow, 0);
    end
    @(negedge clk);
    chk("stuck_ovf", overflow, 1);
    chk("stuck_count", fifo_count, 16);
    chk("stuck_ready", ready, 0);
    chk("stuck_busy", busy, 1);
    repeat (50) @(negedge clk);
    chk("stuck_dv_cnt", dv_cnt, 1);
    do_reset();
    tx_stuck = 1'b0;

    // Reset while byte index 3 is being strobed, with two words still queued.
    push_word(32'hDEADBEEF, 1'b1);
    push_word(32'h01020304, 1'b1);
    push_word(32'h55667788, 1'b1);
    seen = 0;
    n = 0;
    while (seen < 4 && n < 2000) begin
      @(negedge clk);
      n++;
      if (tx_dv) seen++;
    end
    chk("idx3_reached", seen, 4);
    #1 rst_n = 1'b0;
    reset_gen++;
    #1;
    exp_q.delete();
    chk("arst_dv", tx_dv, 0);
    chk("arst_byte", tx_byte, 8'h00);
    chk("arst_busy", busy, 0);
    chk("arst_count", fifo_count, 0);
    chk("arst_ready", ready, 1);
    chk("arst_ovf", overflow, 0);
    repeat (60) @(negedge clk);
    rst_n = 1'b1;
    snap = dv_cnt;
    repeat (100) @(negedge clk);
    chk("post_rst_quiet", dv_cnt - snap, 0);
    chk("post_rst_busy", busy, 0);
    dv_cnt = 0;
    push_word(32'hCAFEF00D, 1'b1);
    wait_idle(2000);
    chk("restart_dv_cnt", dv_cnt, 6);

    // Random bursts with random spacing.
    for (int r = 0; r < 5; r++) begin
      int nw = $urandom_range(1, 4);
      dv_cnt = 0;
      for (int j = 0; j < nw; j++) begin
        push_word($urandom, 1'b1);
        if ($urandom_range(0, 1) == 1) repeat ($urandom_range(1, 60)) @(posedge clk);
      end
      wait_idle(nw * 400 + 200);
      chk("rand_dv_cnt", dv_cnt, nw * 6);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/tdc_uart_framer.md
# tdc_uart_framer

Upstream feeder for the byte-level UART transmitter in the TDC slow-control path. Buffers 32-bit TDC event words in an internal FIFO, wraps each word in a 6-byte frame (sync, four data bytes MSB first, XOR checksum), and drives the transmitter one byte at a time. It uses the transmitter's active/done handshake, so no byte is issued while a previous byte is still on the line.

## Interface
- DEPTH, 16: FIFO depth in 32-bit words; must be a power of two, at least 2.
- SYNC_BYTE, 8'hAA: first byte of every frame.

- i_Clock  in  1  system clock; all logic on its rising edge.
- i_Rst_L  in  1  reset, asynchronous, active-low.
- i_Data_Valid  in  1  producer offers i_Data this cycle.
- i_Data  in  32  TDC event word.
- o_Data_Ready  out  1  FIFO not full; a word is accepted when i_Data_Valid and o_Data_Ready are both 1.
- o_Tx_DV  out  1  one-cycle byte strobe to the transmitter.
- o_Tx_Byte  out  8  byte to transmit; stable from the o_Tx_DV cycle until the next o_Tx_DV.
- i_Tx_Active  in  1  transmitter is busy with a byte.
- i_Tx_Done  in  1  transmitter finished a byte; high for 2 cycles.
- o_Busy  out  1  frame in progress (framer state is not IDLE).
- o_Fifo_Count  out  $clog2(DEPTH)+1  words currently stored.
- o_Overflow  out  1  sticky: i_Data_Valid was seen while o_Data_Ready=0; cleared only by reset.

## Operation
- FIFO: registered read/write pointers with an extra wrap bit. full = count==DEPTH; o_Data_Ready = !full, derived combinationally from the registered count. A push and a pop in the same cycle leave the count unchanged; both happen. A push while full is dropped and sets o_Overflow.
- Framer FSM:
  - IDLE: if count>0, pop the head word into a holding register, clear the checksum, set byte index to 0 → SEND.
  - SEND: drive o_Tx_Byte = frame byte[index], o_Tx_DV=1 for exactly this cycle → WAIT_ACT.
  - WAIT_ACT: wait for i_Tx_Active=1 → WAIT_DONE.
  - WAIT_DONE: wait for i_Tx_Done=1 → GAP.
  - GAP: wait for i_Tx_Done=0, which means the transmitter is back in its idle state. Then, if index==5 → IDLE; otherwise index+1 → SEND.
- Frame bytes by index:
  - 0: SYNC_BYTE
  - 1: word[31:24]
  - 2: word[23:16]
  - 3: word[15:8]
  - 4: word[7:0]
  - 5: word[31:24]^word[23:16]^word[15:8]^word[7:0]. The sync byte is excluded; the checksum is computed combinationally from the holding register.
- Frames are never interleaved. The next word is popped only from IDLE, after the previous frame's last GAP completes.
- There is no timeout. If the transmitter never raises i_Tx_Active, the FSM stays in WAIT_ACT.

## Timing
- Reset values: o_Tx_DV=0, o_Tx_Byte=8'h00, o_Busy=0, o_Overflow=0, o_Fifo_Count=0, o_Data_Ready=1, FSM=IDLE, pointers=0.
- Reset asserted mid-frame: the frame is abandoned immediately, the FIFO is emptied and o_Tx_DV drops asynchronously. After release, no byte is sent until a new word is pushed.
- Push at edge N into an empty FIFO with the FSM in IDLE:
  - o_Fifo_Count=1 after N.
  - Pop at edge N+1; the FSM is in SEND after N+1.
  - o_Tx_DV=1 during cycle N+2 with o_Tx_Byte=SYNC_BYTE.
  - o_Busy=1 from N+1 through the end of the final GAP.
- Inter-byte overhead beyond the transmitter's own byte time: 2 cycles (GAP exit, then SEND).
- o_Tx_DV is never high for two consecutive cycles. It is never high while i_Tx_Active=1 or i_Tx_Done=1.
- o_Overflow sets on the edge after the rejected cycle.

## Test plan
- Single word 32'h12345678, transmitter with CLKS_PER_BIT=4 → serial bytes AA 12 34 56 78 08, each with a correct start and stop bit; o_Busy falls after the 6th i_Tx_Done; o_Fifo_Count returns to 0.
- Push at edge N into an idle block → o_Tx_DV is high only in cycle N+2 with byte 8'hAA; o_Fifo_Count=1 during N+1 and 0 from N+2.
- Transmitter model that never raises i_Tx_Active, then 18 back-to-back pushes starting from empty → 17 accepted (1 popped plus 16 stored); o_Data_Ready=0 from the 17th acceptance; o_Overflow=1 after the 18th; the FSM stays in WAIT_ACT.
- Three words 32'h00000000, 32'hFFFFFFFF, 32'hA5A5A5A5 pushed consecutively → three complete frames in order, with checksums 00, 00, 00; push/pop in the same cycle keeps o_Fifo_Count correct.
- Push with i_Tx_Done held high for 2 cycles per byte (real transmitter) → no o_Tx_DV while i_Tx_Done=1; exactly one o_Tx_DV per byte; 6 per frame.
- i_Rst_L pulsed low during byte index 3 with 2 words queued → all outputs immediately take their reset values; no further o_Tx_DV after release until a new push arrives.
